// File: rtl/tone_bank.sv
// tone_bank: multi-channel programmable square-wave tone generator.
// Each channel's half-period is loaded at run time through a valid/ready command
// port. A new value waits in a per-channel pending slot and is applied only at a
// half-period boundary, so retuning never produces runt pulses. The block outputs
// one registered tone bit per channel and a registered count of how many tone
// bits are high, for the audio/PWM stage.
// Optional feature macro: TONE_DURATION_EN. When it is defined, each command also
// carries a duration in prescaler ticks, and the channel silences itself when that
// duration runs out.
module tone_bank #(
  parameter int NCH   = 4,
  parameter int DIV_W = 26
`ifdef TONE_DURATION_EN
  , parameter int CLK_HZ  = 50_000_000,
  parameter int DUR_W   = 16,
  parameter int TICK_HZ = 1000
`endif
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cmd_ch,
  input  logic [DIV_W-1:0]                        cmd_half,
`ifdef TONE_DURATION_EN
  input  logic [DUR_W-1:0]                        cmd_dur,
`endif
  output logic [NCH-1:0]                          tone_out,
  output logic [$clog2(NCH+1)-1:0]                mix_out,
  output logic [NCH-1:0]                          busy
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MW = $clog2(NCH + 1);

  logic [DIV_W-1:0] r_half     [NCH];
  logic [DIV_W-1:0] r_cnt      [NCH];
  logic [DIV_W-1:0] r_pendHalf [NCH];
  logic [NCH-1:0]   r_pending;
  logic [NCH-1:0]   r_tone;
  logic [MW-1:0]    r_mix;

  logic             w_cmdReady;
  logic [NCH-1:0]   w_accept;
  logic [NCH-1:0]   w_active;
  logic [NCH-1:0]   w_boundary;
  logic [MW-1:0]    w_pop;

`ifdef TONE_DURATION_EN
  localparam int P  = CLK_HZ / TICK_HZ;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  logic [PW-1:0]    r_pre;
  logic [DUR_W-1:0] r_rem     [NCH];
  logic [DUR_W-1:0] r_pendDur [NCH];
  logic             w_tick;
  logic [NCH-1:0]   w_expire;

  // Free-running prescaler producing one tick every P clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign w_tick = (r_pre == PW'(P - 1));
`endif

  // Ready reflects the addressed channel's pending slot; out-of-range channels always accept
  always_comb begin
    w_cmdReady = 1'b1;
    w_accept   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cmd_ch == CW'(i)) begin
        w_cmdReady  = !r_pending[i];
        w_accept[i] = cmd_valid && !r_pending[i];
      end
    end
  end

  // Per-channel activity and half-period boundary detection
  always_comb begin
    w_active   = '0;
    w_boundary = '0;
    for (int i = 0; i < NCH; i++) begin
      w_active[i]   = (r_half[i] != '0);
      w_boundary[i] = w_active[i] && (r_cnt[i] == (r_half[i] - DIV_W'(1)));
    end
  end

`ifdef TONE_DURATION_EN
  // Expiry fires on a tick when the last unit of duration is consumed, unless a pending apply wins
  always_comb begin
    w_expire = '0;
    for (int i = 0; i < NCH; i++) begin
      w_expire[i] = w_tick && w_active[i] && (r_rem[i] == DUR_W'(1)) &&
                    !(w_boundary[i] && r_pending[i]);
    end
  end
`endif

  // Channel engine: counting, toggling, pending apply and command capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_tone    <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_half[i]     <= '0;
        r_cnt[i]      <= '0;
        r_pendHalf[i] <= '0;
`ifdef TONE_DURATION_EN
        r_rem[i]      <= '0;
        r_pendDur[i]  <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_boundary[i] && r_pending[i]) begin
          r_half[i]    <= r_pendHalf[i];
          r_cnt[i]     <= '0;
          r_pending[i] <= 1'b0;
          r_tone[i]    <= (r_pendHalf[i] == '0) ? 1'b0 : !r_tone[i];
`ifdef TONE_DURATION_EN
          r_rem[i]     <= r_pendDur[i];
        end else if (w_expire[i]) begin
          r_half[i]    <= '0;
          r_cnt[i]     <= '0;
          r_tone[i]    <= 1'b0;
          r_rem[i]     <= '0;
`endif
        end else if (w_active[i]) begin
          if (w_boundary[i]) begin
            r_cnt[i]  <= '0;
            r_tone[i] <= !r_tone[i];
          end else begin
            r_cnt[i]  <= r_cnt[i] + DIV_W'(1);
          end
`ifdef TONE_DURATION_EN
          if (w_tick && (r_rem[i] > DUR_W'(1))) begin
            r_rem[i] <= r_rem[i] - DUR_W'(1);
          end
`endif
        end else if (r_pending[i]) begin
          r_half[i]    <= r_pendHalf[i];
          r_cnt[i]     <= '0;
          r_tone[i]    <= 1'b0;
          r_pending[i] <= 1'b0;
`ifdef TONE_DURATION_EN
          r_rem[i]     <= r_pendDur[i];
`endif
        end

        if (w_accept[i]) begin
          r_pending[i]  <= 1'b1;
          r_pendHalf[i] <= cmd_half;
`ifdef TONE_DURATION_EN
          r_pendDur[i]  <= cmd_dur;
`endif
        end
      end
    end
  end

  // Population count of the current tone bits
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NCH; i++) begin
      w_pop = w_pop + MW'(r_tone[i]);
    end
  end

  // Mix level registered one cycle behind the tone bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mix <= '0;
    end else begin
      r_mix <= w_pop;
    end
  end

  // A channel is busy whenever its applied half-period is non-zero
  always_comb begin
    busy = '0;
    for (int i = 0; i < NCH; i++) begin
      busy[i] = w_active[i];
    end
  end

  assign cmd_ready = w_cmdReady;
  assign tone_out  = r_tone;
  assign mix_out   = r_mix;

endmodule

// File: tb/tb_tone_bank.sv
// tb_tone_bank: directed scoreboard bench for tone_bank (NCH=4).
// Expected tone/mix samples are queued when a stimulus step is issued and
// popped one per clock as the DUT produces them. Duration checks are compiled
// only with TONE_DURATION_EN.
module tb_tone_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_ch = '0;
  logic [25:0] cmd_half = '0;
`ifdef TONE_DURATION_EN
  logic [15:0] cmd_dur = '0;
`endif
  logic [3:0]  tone_out;
  logic [2:0]  mix_out;
  logic [3:0]  busy;

  typedef struct {
    logic [3:0] tone;
    logic [2:0] mix;
  } expT;

  expT   expQ[$];
  logic [3:0] lastTone;
  string curTag;
  int    nCompared  = 0;
  int    nMismatched = 0;

`ifdef TONE_DURATION_EN
  tone_bank #(.NCH(4), .DIV_W(26), .CLK_HZ(1000), .DUR_W(16), .TICK_HZ(100)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_half(cmd_half), .cmd_dur(cmd_dur),
    .tone_out(tone_out), .mix_out(mix_out), .busy(busy)
  );
`else
  tone_bank #(.NCH(4), .DIV_W(26)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_half(cmd_half),
    .tone_out(tone_out), .mix_out(mix_out), .busy(busy)
  );
`endif

  // 10-unit clock
  always #5 clk = ~clk;

  // Hard stop in case something hangs
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: through the rising edge, then sample on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Queue one expected sample; mix is the popcount of the previous expected tone
  task automatic pushExp(input logic [3:0] tone);
    expT e;
    e.tone = tone;
    e.mix  = 3'($countones(lastTone));
    expQ.push_back(e);
    lastTone = tone;
  endtask

  task automatic runWindow(input int n);
    expT e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $error("[TB] FAIL %s_sb: observed=empty_queue expected=entry", curTag);
      end else begin
        e = expQ.pop_front();
        checkOutput({curTag, "_tone"}, 32'(tone_out), 32'(e.tone));
        checkOutput({curTag, "_mix"}, 32'(mix_out), 32'(e.mix));
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_tone", 32'(tone_out), 32'h0);
    checkOutput("rst_mix", 32'(mix_out), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    lastTone = '0;
    expQ.delete();
  endtask

  // Issue one command, waiting (bounded) for ready; returns at the falling edge after acceptance
  task automatic applyStimulus(input logic [1:0] ch, input logic [25:0] half);
    int n;
    cmd_ch    = ch;
    cmd_half  = half;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 64) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      nCompared++;
      nMismatched++;
      $error("[TB] FAIL %s_ready_timeout: observed=0 expected=1", curTag);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    lastTone = '0;

    // Test 1: single channel, half=5
    curTag = "t1";
    doReset();
    applyStimulus(2'd0, 26'd5);
    checkOutput("t1_busy_k0", 32'(busy), 32'h0);
    checkOutput("t1_ready_k0", 32'(cmd_ready), 32'h0);
    for (int k = 1; k <= 22; k++) pushExp({3'b000, 1'(((k - 1) / 5) % 2)});
    runWindow(1);
    checkOutput("t1_busy_k1", 32'(busy), 32'h1);
    checkOutput("t1_ready_k1", 32'(cmd_ready), 32'h1);
    runWindow(21);

    // Test 2: retune 4 -> 8 mid half-period, then silence while low
    curTag = "t2";
    doReset();
    applyStimulus(2'd1, 26'd4);
    for (int k = 1; k <= 36; k++) begin
      logic b;
      if (k <= 8)       b = 1'(((k - 1) / 4) % 2);
      else if (k <= 16) b = 1'b0;
      else if (k <= 24) b = 1'b1;
      else              b = 1'b0;
      pushExp({2'b00, b, 1'b0});
    end
    runWindow(6);
    cmd_ch = 2'd1; cmd_half = 26'd8; cmd_valid = 1'b1;
    runWindow(1);
    cmd_valid = 1'b0;
    checkOutput("t2_ready_k7", 32'(cmd_ready), 32'h0);
    runWindow(1);
    checkOutput("t2_ready_k8", 32'(cmd_ready), 32'h0);
    runWindow(1);
    checkOutput("t2_ready_k9", 32'(cmd_ready), 32'h1);
    runWindow(17);
    cmd_ch = 2'd1; cmd_half = 26'd0; cmd_valid = 1'b1;
    runWindow(1);
    cmd_valid = 1'b0;
    runWindow(5);
    checkOutput("t2_busy_k32", 32'(busy), 32'h2);
    runWindow(1);
    checkOutput("t2_busy_k33", 32'(busy), 32'h0);
    runWindow(3);

    // Test 3: half=1 toggles every clock, then silence accepted on a boundary edge
    curTag = "t3";
    doReset();
    applyStimulus(2'd2, 26'd1);
    for (int k = 1; k <= 10; k++) pushExp({1'b0, (k <= 6) ? 1'((k - 1) % 2) : 1'b0, 2'b00});
    runWindow(5);
    cmd_ch = 2'd2; cmd_half = 26'd0; cmd_valid = 1'b1;
    runWindow(1);
    cmd_valid = 1'b0;
    checkOutput("t3_busy_k6", 32'(busy), 32'h4);
    checkOutput("t3_ready_k6", 32'(cmd_ready), 32'h0);
    runWindow(1);
    checkOutput("t3_busy_k7", 32'(busy), 32'h0);
    runWindow(3);

    // Test 4a: all channels half=3 loaded on consecutive silent cycles -> staggered phases
    curTag = "t4a";
    doReset();
    for (int p = 1; p <= 20; p++) begin
      logic [3:0] t;
      for (int c = 0; c < 4; c++) t[c] = (p >= c + 2) ? 1'(((p - c - 2) / 3) % 2) : 1'b0;
      pushExp(t);
    end
    for (int p = 1; p <= 20; p++) begin
      if (p <= 4) begin
        cmd_ch = 2'(p - 1); cmd_half = 26'd3; cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      runWindow(1);
    end
    cmd_valid = 1'b0;

    // Test 4b: channels aligned to a common boundary, then all retuned to 3 together
    curTag = "t4b";
    doReset();
    for (int p = 1; p <= 30; p++) pushExp((p >= 12 && ((p - 12) / 3) % 2 == 0) ? 4'hF : 4'h0);
    for (int p = 1; p <= 30; p++) begin
      if (p <= 8) begin
        cmd_ch    = 2'((p - 1) % 4);
        cmd_half  = (p <= 4) ? 26'(11 - p) : 26'd3;
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      runWindow(1);
    end
    cmd_valid = 1'b0;

    // Test 5: asynchronous reset mid-tone with a pending command
    curTag = "t5";
    doReset();
    applyStimulus(2'd0, 26'd5);
    for (int k = 1; k <= 7; k++) pushExp({3'b000, 1'(((k - 1) / 5) % 2)});
    runWindow(6);
    cmd_ch = 2'd0; cmd_half = 26'd7; cmd_valid = 1'b1;
    runWindow(1);
    cmd_valid = 1'b0;
    checkOutput("t5_ready_pending", 32'(cmd_ready), 32'h0);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rst_tone", 32'(tone_out), 32'h0);
    checkOutput("t5_rst_mix", 32'(mix_out), 32'h0);
    checkOutput("t5_rst_busy", 32'(busy), 32'h0);
    checkOutput("t5_rst_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    lastTone = '0;
    for (int k = 1; k <= 20; k++) pushExp(4'h0);
    runWindow(20);
    checkOutput("t5_busy_after", 32'(busy), 32'h0);

`ifdef TONE_DURATION_EN
    // Test 6: duration-limited tone expires 21..30 clocks after apply; dur=0 never expires
    curTag = "t6";
    doReset();
    begin
      int silAt;
      int dropped;
      cmd_dur = 16'd3;
      applyStimulus(2'd0, 26'd2);
      silAt = -1;
      for (int k = 1; k <= 45 && silAt < 0; k++) begin
        tick();
        if (busy[0] == 1'b0 && k > 1) silAt = k - 1;
      end
      checkOutput("t6_expire_window", 32'((silAt >= 21) && (silAt <= 30)), 32'h1);
      checkOutput("t6_expire_tone", 32'(tone_out), 32'h0);
      cmd_dur = 16'd0;
      applyStimulus(2'd0, 26'd2);
      tick();
      dropped = 0;
      for (int k = 0; k < 100; k++) begin
        tick();
        if (busy[0] == 1'b0) dropped++;
      end
      checkOutput("t6_unlimited", 32'(dropped), 32'h0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
